alu_flow_ctrl: RTL

Sequential flag/program-flow stage directly downstream of the ALU operation circuits. It captures the zero/sign/carry flags from each ALU result into a 4-bit status register (SR), and supplies the carry-in used by add-with-carry and subtract-with-carry. It also resolves program-flow ops (trap, nop, jumps, SR load/XOR) and issues registered branch redirects. After each taken branch it runs a wrong-path flush window, and it holds a trap-mode state machine.

---
 rtl/alu_flow_pkg.sv | 24 ++
 rtl/alu_flow_ctrl_branch_cond.sv | 23 ++
 rtl/alu_flow_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_flow_pkg.sv
// Shared encodings for the ALU flag/program-flow stage: flow opcodes,
// status-register bit positions and the trap-mode FSM state type.
package alu_flow_pkg;

    localparam logic [2:0] OP_TRAP = 3'd0;
    localparam logic [2:0] OP_NOP  = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_JZ   = 3'd3;
    localparam logic [2:0] OP_JS   = 3'd4;
    localparam logic [2:0] OP_JZS  = 3'd5;
    localparam logic [2:0] OP_LSR  = 3'd6;
    localparam logic [2:0] OP_XSR  = 3'd7;

    localparam int SR_Z = 0;
    localparam int SR_S = 1;
    localparam int SR_C = 2;
    localparam int SR_T = 3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

endpackage

// File: rtl/alu_flow_ctrl_branch_cond.sv
// Branch condition evaluation: decides from the opcode and the forwarded
// Z/S flags whether a jump op is taken. Non-jump ops never report taken.
module alu_branch_cond
    import alu_flow_pkg::*;
(
    input  logic [2:0] flow_op_i,
    input  logic       flag_z_i,
    input  logic       flag_s_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (flow_op_i)
            OP_JMP:  taken_o = 1'b1;
            OP_JZ:   taken_o = flag_z_i;
            OP_JS:   taken_o = flag_s_i;
            OP_JZS:  taken_o = flag_z_i | flag_s_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flow_ctrl.sv
// Flag capture, carry-in supply, flow-op resolution, branch redirect, flush
// window and trap FSM. Optional trap shadow of the flags: TRAP_SHADOW_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | normal operation, flow ops accepted when no flush is pending
// ST_TRAP | trap mode, flow ops blocked, flags still captured
module alu_flow_ctrl
    import alu_flow_pkg::*;
#(
    parameter int WIDTH        = 20,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    input  logic             res_zero,
    input  logic             res_sign,
    input  logic             res_carry,
    input  logic [2:0]       res_upd_mask,
    input  logic             flow_valid,
    output logic             flow_ready,
    input  logic [2:0]       flow_op,
    input  logic [WIDTH-1:0] flow_target,
    input  logic [3:0]       flow_imm,
    input  logic             trap_clear,
    output logic [3:0]       sr,
    output logic             carry_in,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_target,
    output logic             flush,
    output logic             trap_active
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_e           state_q;
    logic             trap_active_q;
    logic             t_q;
    logic [2:0]       flags_q;
    logic [2:0]       flags_d;
    logic [2:0]       fwd_flags;
    logic [2:0]       res_flags;
    logic             branch_taken_q;
    logic [WIDTH-1:0] branch_target_q;
    logic [3:0]       flush_cnt_q;
    logic [3:0]       flush_cnt_d;
    logic             flush_active;
    logic             accept;
    logic             flag_upd;
    logic             cond_taken;
    logic             branch_go;
    logic             trap_enter;
    logic             unused_imm_t;

`ifdef TRAP_SHADOW_EN
    logic [2:0]       shadow_q;
    logic             trap_exit;
`endif

    // T is owned by the trap FSM, so the immediate's top bit is never used.
    assign unused_imm_t = flow_imm[SR_T];

    assign flush_active = (flush_cnt_q != 4'd0);
    assign flow_ready   = (state_q == ST_RUN) && !flush_active;
    assign accept       = flow_valid && flow_ready;
    assign flag_upd     = res_valid && !flush_active;
    assign trap_enter   = accept && (flow_op == OP_TRAP);

    assign res_flags[SR_Z] = res_zero;
    assign res_flags[SR_S] = res_sign;
    assign res_flags[SR_C] = res_carry;

    // Flags as they will be after this cycle's ALU write; jumps test these.
    always_comb begin
        fwd_flags = flags_q;
        for (int i = 0; i < 3; i++) begin
            if (flag_upd && res_upd_mask[i]) begin
                fwd_flags[i] = res_flags[i];
            end
        end
    end

    alu_branch_cond u_branch_cond (
        .flow_op_i (flow_op),
        .flag_z_i  (fwd_flags[SR_Z]),
        .flag_s_i  (fwd_flags[SR_S]),
        .taken_o   (cond_taken)
    );

    assign branch_go = accept && cond_taken;

`ifdef TRAP_SHADOW_EN
    assign trap_exit = (state_q == ST_TRAP) && trap_clear;
`endif

    always_comb begin
        flags_d = fwd_flags;
        if (accept && (flow_op == OP_LSR)) begin
            flags_d = flow_imm[2:0];
        end else if (accept && (flow_op == OP_XSR)) begin
            flags_d = flags_q ^ flow_imm[2:0];
        end
`ifdef TRAP_SHADOW_EN
        if (trap_exit) begin
            flags_d = shadow_q;
        end
`endif
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (branch_go) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_active) begin
            flush_cnt_d = flush_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q         <= 3'b000;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            flush_cnt_q     <= 4'd0;
        end else begin
            flags_q        <= flags_d;
            branch_taken_q <= branch_go;
            flush_cnt_q    <= flush_cnt_d;
            if (branch_go) begin
                branch_target_q <= flow_target;
            end
        end
    end

    // Trap entry wins over a simultaneous trap_clear since clear is only
    // examined once the FSM is already in ST_TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            trap_active_q <= 1'b0;
            t_q           <= 1'b0;
`ifdef TRAP_SHADOW_EN
            shadow_q      <= 3'b000;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (trap_enter) begin
                        state_q       <= ST_TRAP;
                        trap_active_q <= 1'b1;
                        t_q           <= 1'b1;
`ifdef TRAP_SHADOW_EN
                        shadow_q      <= flags_q;
`endif
                    end
                end
                ST_TRAP: begin
                    if (trap_clear) begin
                        state_q       <= ST_RUN;
                        trap_active_q <= 1'b0;
                        t_q           <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_RUN;
                    trap_active_q <= 1'b0;
                    t_q           <= 1'b0;
                end
            endcase
        end
    end

    assign sr            = {t_q, flags_q};
    assign carry_in      = flags_q[SR_C];
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign flush         = flush_active;
    assign trap_active   = trap_active_q;

endmodule
